// File: rtl/mw_add_defs.sv
// Shared definitions for the multi-word add/sub sequencer.
// Provides the word width and the FSM state encodings.
package mw_add_defs;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mw_add_seq_rca.sv
// RCA_32bit: 32-bit ripple-carry word adder.
// Ports: a, b, cin in; sum, cout out.
module RCA_32bit (
  output logic [31:0] sum,
  output logic        cout,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin
);

  for (genvar i = 0; i < 32; i++) begin : g_fa
    logic ci;
    logic co;
    if (i == 0) begin : g_lsb
      assign ci = cin;
    end else begin : g_up
      assign ci = g_fa[i-1].co;
    end
    assign sum[i] = a[i] ^ b[i] ^ ci;
    assign co = (a[i] & b[i])
              | (ci & (a[i] ^ b[i]));
  end

  assign cout = g_fa[31].co;

endmodule

// File: rtl/mw_add_seq.sv
// mw_add_seq: wide add/sub, one 32-bit word per cycle, LSW first.
// Ports: clk, rst_n, start/op_a/op_b/cin/sub in; busy, done, sum, cout, ovf out.
module mw_add_seq
  import mw_add_defs::*;
#(
  parameter int NUM_WORDS = 2,
  localparam int W = WORD_W * NUM_WORDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         cin,
  input  logic         sub,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int IW =
    (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IW-1:0] LAST =
    IW'(NUM_WORDS - 1);

  typedef logic [NUM_WORDS-1:0][WORD_W-1:0] wvec_t;

  state_t state_q;
  state_t state_d;

  wvec_t a_q;
  wvec_t b_q;
  wvec_t acc_q;
  wvec_t acc_d;

  logic [IW-1:0] idx_q;
  logic          carry_q;
  logic [W-1:0]  sum_q;
  logic          cout_q;
  logic          ovf_q;

  logic accept;
  logic step;
  logic last;

  logic [WORD_W-1:0] wa;
  logic [WORD_W-1:0] wb;
  logic [WORD_W-1:0] ws;
  logic              wc;
  logic              c_msb;

  assign wa   = a_q[idx_q];
  assign wb   = b_q[idx_q];
  assign last = (idx_q == LAST);

  RCA_32bit u_rca (
    .sum  (ws),
    .cout (wc),
    .a    (wa),
    .b    (wb),
    .cin  (carry_q)
  );

  // Carry into the MSB recovered from the sum bit,
  // since the word adder only exposes its carry-out.
  assign c_msb = wa[WORD_W-1]
               ^ wb[WORD_W-1]
               ^ ws[WORD_W-1];

  always_comb begin
    acc_d        = acc_q;
    acc_d[idx_q] = ws;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end
      end
      (state_q == ST_RUN): begin
        step = 1'b1;
        if (last) begin
          state_d = ST_DONE;
        end
      end
      (state_q == ST_DONE): begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (accept) begin
        a_q     <= op_a;
        // Subtract as A + ~B + 1.
        b_q     <= sub ? ~op_b : op_b;
        carry_q <= sub ? 1'b1 : cin;
        idx_q   <= '0;
      end
      if (step) begin
        acc_q   <= acc_d;
        carry_q <= wc;
        idx_q   <= last ? '0 : idx_q + IW'(1);
        if (last) begin
          sum_q  <= acc_d;
          cout_q <= wc;
          ovf_q  <= wc ^ c_msb;
        end
      end
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_mw_add_seq.sv
// Scoreboard bench for mw_add_seq.
// Random and corner operands against an arithmetic reference.
module tb_mw_add_seq;

  localparam int NW = 2;
  localparam int W  = 32 * NW;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  mw_add_seq #(.NUM_WORDS(NW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op_a  (op_a),
    .op_b  (op_b),
    .cin   (cin),
    .sub   (sub),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc++;

  task automatic chk(string name,
                     logic [W-1:0] act,
                     logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h",
               name, act, req);
    end
  endtask

  function automatic exp_t model(logic [W-1:0] a,
                                 logic [W-1:0] b,
                                 logic ci,
                                 logic sb);
    exp_t e;
    logic [W:0] t;
    if (sb) begin
      e.s  = a - b;
      e.co = (a >= b);
      e.ov = (a[W-1] != b[W-1])
          && (e.s[W-1] != a[W-1]);
    end else begin
      t    = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
      e.s  = t[W-1:0];
      e.co = t[W];
      e.ov = (a[W-1] == b[W-1])
          && (e.s[W-1] != a[W-1]);
    end
    e.cyc = 0;
    return e;
  endfunction

  // Monitor: pops on done, checks hold otherwise.
  exp_t         mon_e;
  logic [W-1:0] last_sum;
  logic         last_co;
  logic         last_ov;
  logic         prev_done = 1'b0;
  logic         rst_edge  = 1'b1;

  always @(posedge clk) rst_edge = !rst_n;

  always @(negedge clk) begin
    if (rst_edge) begin
      prev_done = 1'b0;
    end else if (done) begin
      chk("done_width", W'(prev_done), '0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done actual=1 required=0");
      end else begin
        mon_e = exp_q.pop_front();
        chk("sum", sum, mon_e.s);
        chk("cout", W'(cout), W'(mon_e.co));
        chk("ovf", W'(ovf), W'(mon_e.ov));
        chk("latency", W'(cyc), W'(mon_e.cyc + NW));
      end
    end else begin
      chk("sum_hold", sum, last_sum);
      chk("cout_hold", W'(cout), W'(last_co));
      chk("ovf_hold", W'(ovf), W'(last_ov));
    end
    last_sum  = sum;
    last_co   = cout;
    last_ov   = ovf;
    prev_done = done;
  end

  task automatic issue(logic [W-1:0] a,
                       logic [W-1:0] b,
                       logic ci,
                       logic sb,
                       bit collide);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout actual=busy required=idle");
      return;
    end
    op_a  = a;
    op_b  = b;
    cin   = ci;
    sub   = sb;
    start = 1'b1;
    @(negedge clk);
    e     = model(a, b, ci, sb);
    e.cyc = cyc;
    exp_q.push_back(e);
    chk("accept_busy", W'(busy), W'(1));
    start = 1'b0;
    op_a  = {$urandom, $urandom};
    op_b  = {$urandom, $urandom};
    cin   = 1'($urandom);
    sub   = 1'($urandom);
    if (collide) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0: v = '0;
      1: v = '1;
      2: v = {1'b0, {(W-1){1'b1}}};
      3: v = {1'b1, {(W-1){1'b0}}};
      4: v = {32'h0, 32'hFFFF_FFFF};
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    op_a  = {$urandom, $urandom};
    op_b  = {$urandom, $urandom};
    cin   = 1'b1;
    sub   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_sum", sum, '0);
    chk("rst_cout", W'(cout), '0);
    chk("rst_ovf", W'(ovf), '0);
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("rst_no_accept", W'(busy), '0);

    issue(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 0);
    issue(64'h0000_0000_AAB1_2FCD,
          64'h0000_0000_AAAA_BBBC, 1'b0, 1'b0, 0);
    issue('1, 64'h1, 1'b0, 1'b0, 0);
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 0);
    issue(64'd5, 64'd7, 1'b1, 1'b1, 0);
    issue(64'd7, 64'd5, 1'b0, 1'b1, 0);
    issue(64'h1234_5678_9ABC_DEF0,
          64'h0FED_CBA9_8765_4321, 1'b1, 1'b0, 1);

    // Abort mid-run: no done, result registers cleared.
    issue(64'h1111_2222_3333_4444,
          64'h5555_6666_7777_8888, 1'b0, 1'b0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
    chk("abort_busy", W'(busy), '0);
    chk("abort_done", W'(done), '0);
    chk("abort_sum", sum, '0);
    chk("abort_cout", W'(cout), '0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", W'(done), '0);
    end
    issue(64'hDEAD_BEEF_0000_0001,
          64'h0000_0001_FFFF_FFFF, 1'b1, 1'b0, 0);

    for (int i = 0; i < 150; i++) begin
      issue(pick(), pick(),
            1'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0));
    end

    begin
      int n = 0;
      while (exp_q.size() > 0 && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d required=0",
               exp_q.size());
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mw_add_seq.md
Name: mw_add_seq

Overview:
- Multi-word adder/subtractor sequencer that time-shares one 32-bit ripple-carry adder (RCA_32bit) to add or subtract wide operands, one 32-bit word per cycle, least-significant word first, with a registered carry chain between words.
- Sits between a requesting datapath (start/done handshake) and the shared word adder.
- Serves as the area-cheap alternative to a flat wide RCA.

Parameters:
- NUM_WORDS, 2, number of 32-bit words per operand (>=1); operand width W = 32*NUM_WORDS.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; sampled only when busy=0
- op_a  input  W  operand A, latched at accept
- op_b  input  W  operand B, latched at accept
- cin  input  1  carry-in for add; ignored when sub=1
- sub  input  1  1 = A-B, 0 = A+B+cin; latched at accept
- busy  output  1  high from accept through the done cycle
- done  output  1  one-cycle pulse, result valid
- sum  output  W  result, registered
- cout  output  1  final carry-out (sub: 1 = no borrow)
- ovf  output  1  signed overflow of the W-bit result

Behaviour:
- Reset, synchronous, rst_n=0 at an edge:
  - state=IDLE; busy, done, sum, cout and ovf all 0; word index and carry 0.
  - Aborts any in-flight operation; no done is produced for it.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - A start=1 sampled at edge e0 accepts the request.
  - Latch op_a; latch op_b (stored as ~op_b when sub=1).
  - Carry register = sub ? 1 : cin.
  - idx=0; go to RUN; busy=1 from e0.
- RUN:
  - Each edge writes the word-adder result for word idx into the working register and the word carry-out into the carry register, then idx++.
  - The adder inputs are latched A[idx], B'[idx] and the carry register.
  - The edge that processes word NUM_WORDS-1 (edge e_NUM_WORDS) also:
    - copies the full working result to sum;
    - sets cout = final word carry;
    - sets ovf = carry into MSB XOR carry out of MSB;
    - sets done=1 and goes to DONE.
- DONE: lasts one cycle. On the next edge, done=0, busy=0, go to IDLE.
- Latency and throughput:
  - done is high during the cycle after edge e_NUM_WORDS.
  - Throughput is one operation per NUM_WORDS+2 cycles.
- sum, cout and ovf change only at the completion edge or on reset. They hold stable otherwise, including during a later RUN, until the next completion.
- start while busy=1 is ignored, with no queuing. Operand and sub changes after accept have no effect.
- NUM_WORDS=1: RUN lasts one edge; done appears one cycle after accept.
- Index wrap: idx is clog2-sized and never exceeds NUM_WORDS-1. No wrap occurs inside an operation.
- Reset asserted in the same cycle as start: reset wins; nothing is accepted.

Decomposition:
- Shared include/package mw_add_defs holds:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - WORD_W=32.
- One sub-module: the existing RCA_32bit (ports sum, cout, a, b, cin), instantiated exactly once and driven by the word mux. Do not duplicate it per word.

Test Plan:
- Reset: rst_n=0 for 2 edges with start=1 -> busy=0, done=0, sum=0, cout=0, ovf=0; nothing accepted.
- Cross-word carry (NUM_WORDS=2): a=64'h0000_0000_FFFF_FFFF, b=64'h1, cin=0, sub=0 ->
  - done pulses exactly one cycle, in the cycle after the 2nd edge following accept;
  - sum=64'h0000_0001_0000_0000, cout=0, ovf=0.
- Known word values: a=64'h0000_0000_AAB1_2FCD, b=64'h0000_0000_AAAA_BBBC -> sum=64'h0000_0001_555B_EB89, cout=0.
- Carry/overflow corners:
  - a=64'hFFFF_FFFF_FFFF_FFFF, b=1 -> sum=0, cout=1, ovf=0.
  - a=64'h7FFF_FFFF_FFFF_FFFF, b=1 -> sum=64'h8000_0000_0000_0000, cout=0, ovf=1.
- Subtract: a=5, b=7, sub=1, cin=1 (ignored) -> sum=64'hFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0. Separately, a=7, b=5 -> sum=2, cout=1.
- Handshake robustness:
  - A second start with different operands during RUN is ignored; the result matches the first operation.
  - Pulling rst_n low mid-RUN leaves done, sum and cout at 0; the next accepted operation completes correctly.
